// File: rtl/filter_bank_pkg.sv
// Shared settings for the multi-channel filter bank: sample width, channel count
// and the run-time filter mode encoding.
package filter_bank_pkg;

    localparam int SIZE_ADC_DATA       = 12;
    localparam int SIZE_FILTER_BANK_CH = 4;

    typedef enum logic [1:0] {
        FM_BYPASS = 2'd0,
        FM_SUM    = 2'd1,
        FM_DIFF   = 2'd2,
        FM_BASE   = 2'd3
    } filter_mode_t;

    // Signed width that holds every mode result without loss for a given delay depth.
    function automatic int full_out_width(input int depth);
        return SIZE_ADC_DATA + $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/filter_bank_channel.sv
// One filter-bank lane: delay line, running sum, stage-1 registers and the
// stage-2 mode mux with optional output clamp.
module filter_bank_channel
    import filter_bank_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OUT_W = SIZE_ADC_DATA + $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     shift_i,
    input  logic                     load_i,
    input  logic [1:0]               mode_i,
    input  logic [SIZE_ADC_DATA-1:0] x_i,
    output logic [OUT_W-1:0]         y_o,
    output logic                     sat_o
);

    localparam int A_W  = SIZE_ADC_DATA;
    localparam int L_W  = $clog2(DEPTH);
    localparam int S_W  = A_W + L_W;
    localparam int FW   = S_W + 1;

    logic [A_W-1:0] dl_q [DEPTH];
    logic [A_W-1:0] x_q;
    logic [A_W-1:0] d_q;
    logic [S_W-1:0] sum_q;
    logic [S_W-1:0] sum_d;

    // The sum is a window of DEPTH unsigned samples, so it cannot exceed S_W bits.
    assign sum_d = sum_q + S_W'(x_i) - S_W'(dl_q[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (reset_i || clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl_q[i] <= '0;
            end
            sum_q <= '0;
            x_q   <= '0;
            d_q   <= '0;
        end else if (shift_i) begin
            dl_q[0] <= x_i;
            for (int i = 1; i < DEPTH; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
            sum_q <= sum_d;
            x_q   <= x_i;
            d_q   <= dl_q[DEPTH-1];
        end
    end

    logic signed [FW-1:0] x_s;
    logic signed [FW-1:0] d_s;
    logic signed [FW-1:0] s_s;
    logic signed [FW-1:0] m_s;
    logic signed [FW-1:0] y_full;
    logic [OUT_W-1:0]     y_sat;
    logic                 sat_c;

    assign x_s = signed'(FW'(x_q));
    assign d_s = signed'(FW'(d_q));
    assign s_s = signed'(FW'(sum_q));
    assign m_s = signed'(FW'(sum_q >> L_W));

    always_comb begin
        y_full = x_s;
        case (filter_mode_t'(mode_i))
            FM_BYPASS: y_full = x_s;
            FM_SUM:    y_full = s_s;
            FM_DIFF:   y_full = x_s - d_s;
            FM_BASE:   y_full = x_s - m_s;
            default:   y_full = x_s;
        endcase
    end

    generate
        if (OUT_W < FW) begin : g_clamp
            localparam int                   MAX_I = (1 << (OUT_W - 1)) - 1;
            localparam logic signed [FW-1:0] Y_MAX = FW'(MAX_I);
            localparam logic signed [FW-1:0] Y_MIN = FW'(-MAX_I - 1);

            always_comb begin
                sat_c = 1'b0;
                y_sat = y_full[OUT_W-1:0];
                if (y_full > Y_MAX) begin
                    y_sat = Y_MAX[OUT_W-1:0];
                    sat_c = 1'b1;
                end else if (y_full < Y_MIN) begin
                    y_sat = Y_MIN[OUT_W-1:0];
                    sat_c = 1'b1;
                end
            end
        end else begin : g_extend
            assign y_sat = OUT_W'(y_full);
            assign sat_c = 1'b0;
        end
    endgenerate

    // Stage 2 only updates on a qualified output so the word holds between strobes.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            y_o   <= '0;
            sat_o <= 1'b0;
        end else if (load_i) begin
            y_o   <= y_sat;
            sat_o <= sat_c;
        end
    end

endmodule

// File: rtl/filter_bank.sv
// Multi-channel running-sum shaper: shared fill counter, mode register and
// valid pipeline around NUM_CH identical channel datapaths.
module filter_bank
    import filter_bank_pkg::*;
#(
    parameter int NUM_CH = SIZE_FILTER_BANK_CH,
    parameter int DEPTH  = 16,
    parameter int OUT_W  = SIZE_ADC_DATA + $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic [1:0]                      mode,
    input  logic                            in_valid,
    input  logic [NUM_CH*SIZE_ADC_DATA-1:0] in_data,
    output logic                            out_valid,
    output logic [NUM_CH*OUT_W-1:0]         out_data,
    output logic [NUM_CH-1:0]               sat_flag
);

    localparam int                FILL_W    = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              v1_q;
    logic              v1_d;
    logic              v2_q;
    logic              v2_d;
    filter_mode_t      mode_q;
    filter_mode_t      mode_d;
    logic              accept;
    logic              load_s2;

    // clear wins over a coincident sample and kills whatever sits in stage 1.
    assign accept  = in_valid & ~clear;
    assign load_s2 = v1_q & ~clear;

    always_comb begin
        fill_d = fill_q;
        mode_d = mode_q;
        v1_d   = accept && (fill_q == FILL_FULL);
        v2_d   = load_s2;
        if (clear) begin
            fill_d = '0;
        end else if (accept) begin
            mode_d = filter_mode_t'(mode);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            mode_q <= FM_BYPASS;
        end else begin
            fill_q <= fill_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            mode_q <= mode_d;
        end
    end

    assign out_valid = v2_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            filter_bank_channel #(
                .DEPTH (DEPTH),
                .OUT_W (OUT_W)
            ) u_ch (
                .clk     (clk),
                .reset_i (reset),
                .clear_i (clear),
                .shift_i (accept),
                .load_i  (load_s2),
                .mode_i  (mode_q),
                .x_i     (in_data[gi*SIZE_ADC_DATA +: SIZE_ADC_DATA]),
                .y_o     (out_data[gi*OUT_W +: OUT_W]),
                .sat_o   (sat_flag[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_filter_bank.sv
// Scoreboard bench: a sample-window reference model feeds expected words into a
// queue; a negedge monitor pops them against a full-width and a clamped instance.
module tb_filter_bank;

    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int A_W   = 12;
    localparam int FW    = 21;
    localparam int CW    = 12;

    typedef struct packed {
        int                    due;
        logic [NCH*FW-1:0]     full;
        logic [NCH*CW-1:0]     clip;
        logic [NCH-1:0]        sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic [1:0]           mode;
    logic                 in_valid;
    logic [NCH*A_W-1:0]   in_data;
    logic                 out_valid_a;
    logic [NCH*FW-1:0]    out_data_a;
    logic [NCH-1:0]       sat_a;
    logic                 out_valid_b;
    logic [NCH*CW-1:0]    out_data_b;
    logic [NCH-1:0]       sat_b;

    filter_bank #(.NUM_CH(NCH), .DEPTH(DEPTH), .OUT_W(FW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_a), .out_data(out_data_a), .sat_flag(sat_a)
    );

    filter_bank #(.NUM_CH(NCH), .DEPTH(DEPTH), .OUT_W(CW)) dut_clip (
        .clk(clk), .reset(reset), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_b), .out_data(out_data_b), .sat_flag(sat_b)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_acc = 0;
    int   last_rst = -10;
    exp_t sb[$];
    int   hist [NCH][$];

    logic [NCH*FW-1:0] hold_full = '0;
    logic [NCH*CW-1:0] hold_clip = '0;
    logic [NCH-1:0]    hold_sat  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [NCH*FW-1:0] act,
                       input logic [NCH*FW-1:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    // Reference: each channel keeps the last DEPTH accepted samples since reset/clear.
    task automatic model(input bit v, input bit c, input bit r,
                         input logic [NCH*A_W-1:0] data, input logic [1:0] m);
        exp_t e;
        int   x, d, s, y, yc;
        if (r || c) begin
            while (sb.size() > 0 && sb[$].due == cyc + 1) void'(sb.pop_back());
            for (int ch = 0; ch < NCH; ch++) hist[ch].delete();
            n_acc = 0;
            if (r) last_rst = cyc;
            return;
        end
        if (!v) return;
        e = '0;
        e.due = cyc + 2;
        for (int ch = 0; ch < NCH; ch++) begin
            x = int'(data[ch*A_W +: A_W]);
            d = (hist[ch].size() == DEPTH) ? hist[ch][0] : 0;
            hist[ch].push_back(x);
            if (hist[ch].size() > DEPTH) void'(hist[ch].pop_front());
            s = 0;
            for (int k = 0; k < hist[ch].size(); k++) s += hist[ch][k];
            case (m)
                2'd0:    y = x;
                2'd1:    y = s;
                2'd2:    y = x - d;
                default: y = x - s / DEPTH;
            endcase
            yc = y;
            if (y > 2047) begin
                yc = 2047;
                e.sat[ch] = 1'b1;
            end else if (y < -2048) begin
                yc = -2048;
                e.sat[ch] = 1'b1;
            end
            e.full[ch*FW +: FW] = y[FW-1:0];
            e.clip[ch*CW +: CW] = yc[CW-1:0];
        end
        if (n_acc >= DEPTH) sb.push_back(e);
        n_acc++;
    endtask

    task automatic step(input bit v, input logic [NCH*A_W-1:0] data, input logic [1:0] m,
                        input bit c, input bit r);
        in_valid = v;
        in_data  = data;
        mode     = m;
        clear    = c;
        reset    = r;
        model(v, c, r, data, m);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*A_W-1:0] rep(input int x);
        logic [A_W-1:0] v;
        v = x[A_W-1:0];
        return {NCH{v}};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            chk(out_valid_b == out_valid_a, "valid_match", NCH*FW'(out_valid_b), NCH*FW'(out_valid_a));
            if (cyc == last_rst + 1) begin
                chk(!out_valid_a && out_data_a == '0 && sat_a == '0 && out_data_b == '0 && sat_b == '0,
                    "reset_zero", out_data_a | NCH*FW'(out_data_b), '0);
                hold_full = '0;
                hold_clip = '0;
                hold_sat  = '0;
            end
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk(1'b0, "missing_output", '0, NCH*FW'(e.due));
            end
            if (out_valid_a) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_valid", out_data_a, '0);
                end else begin
                    e = sb.pop_front();
                    chk(e.due == cyc, "latency", NCH*FW'(cyc), NCH*FW'(e.due));
                    chk(out_data_a == e.full, "data_full", out_data_a, e.full);
                    chk(sat_a == '0, "sat_full", NCH*FW'(sat_a), '0);
                    chk(out_data_b == e.clip, "data_clip", NCH*FW'(out_data_b), NCH*FW'(e.clip));
                    chk(sat_b == e.sat, "sat_clip", NCH*FW'(sat_b), NCH*FW'(e.sat));
                    hold_full = e.full;
                    hold_clip = e.clip;
                    hold_sat  = e.sat;
                end
            end else if (cyc != last_rst + 1) begin
                chk(out_data_a == hold_full && out_data_b == hold_clip && sat_b == hold_sat,
                    "hold", out_data_a, hold_full);
            end
        end
    end

    initial begin
        logic [NCH*A_W-1:0] dat;
        logic [1:0]         m;
        bit                 v, c, r;

        step(0, '0, 2'd0, 0, 1);
        step(0, '0, 2'd0, 0, 1);

        // Constant 100 in SUM mode: 1600 once the window fills.
        repeat (20) step(1, rep(100), 2'd1, 0, 0);

        // Step 0 -> 1000 at sample 20 in DIFF, then in BASE.
        step(0, '0, 2'd2, 1, 0);
        for (int i = 1; i <= 50; i++) step(1, rep(i >= 20 ? 1000 : 0), 2'd2, 0, 0);
        step(0, '0, 2'd3, 1, 0);
        for (int i = 1; i <= 50; i++) step(1, rep(i >= 20 ? 1000 : 0), 2'd3, 0, 0);

        // Full-scale SUM saturates the narrow instance, then decays back in range.
        step(0, '0, 2'd1, 1, 0);
        repeat (20) step(1, rep(4095), 2'd1, 0, 0);
        repeat (20) step(1, rep(0), 2'd1, 0, 0);

        // clear together with a sample mid-stream.
        repeat (5) step(1, rep(100), 2'd1, 0, 0);
        step(1, rep(777), 2'd1, 1, 0);
        repeat (20) step(1, rep(100), 2'd1, 0, 0);

        // Sparse strobes with a one-sample switch to BYPASS.
        for (int i = 0; i < 12; i++) begin
            step(1, rep(200 + i * 10), (i == 6) ? 2'd0 : 2'd1, 0, 0);
            step(0, '0, 2'd2, 0, 0);
            step(0, '0, 2'd3, 0, 0);
        end

        // reset mid-stream.
        repeat (10) step(1, rep(55), 2'd1, 0, 0);
        step(1, rep(66), 2'd1, 0, 1);
        repeat (20) step(1, rep(66), 2'd1, 0, 0);

        // Randomised run with occasional clear and reset.
        for (int i = 0; i < 12500; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                case ($urandom_range(0, 5))
                    0:       dat[ch*A_W +: A_W] = '1;
                    1:       dat[ch*A_W +: A_W] = '0;
                    default: dat[ch*A_W +: A_W] = A_W'($urandom);
                endcase
            end
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 599) == 0);
            r = ($urandom_range(0, 899) == 0);
            m = 2'($urandom);
            step(v, dat, m, c, r);
        end

        repeat (5) step(0, '0, 2'd0, 0, 0);
        chk(sb.size() == 0, "scoreboard_empty", NCH*FW'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
